clic_hart_irq: RTL

Core-side receiver for the CLIC interrupt request interface; it sits inside the hart between the CLIC target arbiter and the core's trap logic. It takes the arbiter's valid/id/level/mode offer and applies the privilege-mode, global-enable, threshold and current-level preemption rules. It then forwards an eligible request to the core and completes the valid/ready handshake only when the core actually takes the trap. It also keeps a bounded stack of saved interrupt levels for nested preemption, popped on `mret_i`.

---
 rtl/clic_hart_irq.sv | 116 +++++++++++
 1 files changed

// File: rtl/clic_hart_irq.sv
// Core-side CLIC request receiver: filters arbiter offers by mode/enable/threshold/level,
// forwards one to the core, and keeps a bounded stack of preempted levels for nesting.
module clic_hart_irq #(
    parameter int N_SOURCE   = 256,
    parameter int PrioWidth  = 8,
    parameter int ModeWidth  = 2,
    parameter int NestDepth  = 4,
    parameter int SrcWidth   = $clog2(N_SOURCE),
    parameter int DepthWidth = $clog2(NestDepth + 1)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  irq_valid_i,
    output logic                  irq_ready_o,
    input  logic [SrcWidth-1:0]   irq_id_i,
    input  logic [PrioWidth-1:0]  irq_max_i,
    input  logic [ModeWidth-1:0]  irq_mode_i,
    input  logic [ModeWidth-1:0]  priv_mode_i,
    input  logic                  glob_ie_i,
    input  logic [PrioWidth-1:0]  thresh_i,
    output logic                  core_irq_req_o,
    output logic [SrcWidth-1:0]   core_irq_id_o,
    output logic [PrioWidth-1:0]  core_irq_level_o,
    output logic [ModeWidth-1:0]  core_irq_mode_o,
    input  logic                  core_irq_ack_i,
    input  logic                  mret_i,
    output logic [PrioWidth-1:0]  cur_level_o,
    output logic [DepthWidth-1:0] depth_o,
    output logic                  stack_full_o
);

    localparam int IdxWidth = (NestDepth > 1) ? $clog2(NestDepth) : 1;

    typedef enum logic [1:0] {
        IDLE,
        PEND,
        HOLD
    } state_t;

    state_t                state_q, state_d;
    logic [SrcWidth-1:0]   id_q;
    logic [PrioWidth-1:0]  level_q;
    logic [ModeWidth-1:0]  mode_q;
    logic [PrioWidth-1:0]  cur_level_q;
    logic [PrioWidth-1:0]  stack_q [NestDepth];
    logic [DepthWidth-1:0] depth_q;
    logic [DepthWidth-1:0] depth_m1;

    logic                  stack_full;
    logic [PrioWidth-1:0]  ceiling;
    logic                  elig;
    logic                  id_match;
    logic                  handshake;
    logic                  pop;

    assign stack_full = (depth_q == DepthWidth'(NestDepth));
    assign ceiling    = (cur_level_q > thresh_i) ? cur_level_q : thresh_i;
    assign elig       = irq_valid_i & ~stack_full &
                        ((irq_mode_i > priv_mode_i) |
                         ((irq_mode_i == priv_mode_i) & glob_ie_i & (irq_max_i > ceiling)));
    assign id_match   = (irq_id_i == id_q);
    // An mret in the same cycle as the ack wins; the handshake retries after the pop.
    assign handshake  = (state_q == PEND) & elig & id_match & core_irq_ack_i & ~mret_i;
    assign pop        = mret_i & (depth_q != '0);
    assign depth_m1   = depth_q - DepthWidth'(1);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (elig) state_d = PEND;
            PEND: begin
                if (!elig || !id_match) state_d = IDLE;
                else if (handshake)     state_d = HOLD;
            end
            HOLD:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            id_q        <= '0;
            level_q     <= '0;
            mode_q      <= '0;
            cur_level_q <= '0;
            depth_q     <= '0;
            for (int i = 0; i < NestDepth; i++) stack_q[i] <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && elig) begin
                id_q    <= irq_id_i;
                level_q <= irq_max_i;
                mode_q  <= irq_mode_i;
            end
            if (handshake) begin
                stack_q[depth_q[IdxWidth-1:0]] <= cur_level_q;
                depth_q                        <= depth_q + DepthWidth'(1);
                cur_level_q                    <= level_q;
            end else if (pop) begin
                cur_level_q <= stack_q[depth_m1[IdxWidth-1:0]];
                depth_q     <= depth_m1;
            end
        end
    end

    assign irq_ready_o      = handshake;
    assign core_irq_req_o   = (state_q == PEND);
    assign core_irq_id_o    = id_q;
    assign core_irq_level_o = level_q;
    assign core_irq_mode_o  = mode_q;
    assign cur_level_o      = cur_level_q;
    assign depth_o          = depth_q;
    assign stack_full_o     = stack_full;

endmodule
